// File: rtl/cla_share_arbiter.sv
// Two-requester front end sharing one 32-bit carry-lookahead adder.
// Requests are granted round-robin and operands are latched. The sum is
// captured after CALC_CYCLES cycles and held until the owner accepts it.
module cla_share_arbiter #(
  parameter int unsigned CALC_CYCLES = 1
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [1:0]  req_valid,
  output logic [1:0]  req_ready,
  input  logic [31:0] req_a0,
  input  logic [31:0] req_b0,
  input  logic        req_cin0,
  input  logic [31:0] req_a1,
  input  logic [31:0] req_b1,
  input  logic        req_cin1,
  output logic [1:0]  rsp_valid,
  input  logic [1:0]  rsp_ready,
  output logic [31:0] rsp_sum,
  output logic        rsp_cout,
  output logic        rsp_of,
  output logic        busy
);

  typedef enum logic [1:0] {StIdle, StCalc, StResp} state_e;

  localparam logic [3:0] CntLoad = 4'(CALC_CYCLES - 1);

  state_e      state_q, state_d;
  logic [3:0]  cnt_q, cnt_d;
  logic        owner_q, owner_d;
  logic        last_q, last_d;
  logic [31:0] op_a_q, op_a_d;
  logic [31:0] op_b_q, op_b_d;
  logic        op_cin_q, op_cin_d;
  logic [31:0] sum_q, sum_d;
  logic        cout_q, cout_d;
  logic        of_q, of_d;

  logic        grant_id;
  logic [31:0] cla_g, cla_p, cla_sum;
  logic [32:0] cla_c;
  logic [7:0]  grp_g, grp_p;
  logic [8:0]  grp_c;
  logic        cla_of;

  // On a tie the requester not served last wins; otherwise the lone requester.
  always_comb grant_id = (&req_valid) ? ~last_q : req_valid[1];

  // Shared adder: 4-bit lookahead groups with a group-level carry chain.
  always_comb begin
    cla_g = op_a_q & op_b_q;
    cla_p = op_a_q ^ op_b_q;
    grp_g = '0;
    grp_p = '0;
    grp_c = '0;
    cla_c = '0;
    for (int k = 0; k < 8; k++) begin
      grp_p[k] = &cla_p[4*k +: 4];
      grp_g[k] = cla_g[4*k+3]
               | (cla_p[4*k+3] & cla_g[4*k+2])
               | (cla_p[4*k+3] & cla_p[4*k+2] & cla_g[4*k+1])
               | ((&cla_p[4*k+1 +: 3]) & cla_g[4*k]);
    end
    grp_c[0] = op_cin_q;
    for (int k = 0; k < 8; k++) begin
      grp_c[k+1] = grp_g[k] | (grp_p[k] & grp_c[k]);
    end
    for (int k = 0; k < 8; k++) begin
      cla_c[4*k]   = grp_c[k];
      cla_c[4*k+1] = cla_g[4*k] | (cla_p[4*k] & grp_c[k]);
      cla_c[4*k+2] = cla_g[4*k+1] | (cla_p[4*k+1] & cla_g[4*k])
                   | (cla_p[4*k+1] & cla_p[4*k] & grp_c[k]);
      cla_c[4*k+3] = cla_g[4*k+2] | (cla_p[4*k+2] & cla_g[4*k+1])
                   | (cla_p[4*k+2] & cla_p[4*k+1] & cla_g[4*k])
                   | ((&cla_p[4*k +: 3]) & grp_c[k]);
    end
    cla_c[32] = grp_c[8];
    cla_sum   = cla_p ^ cla_c[31:0];
    cla_of    = (op_a_q[31] == op_b_q[31]) && (cla_sum[31] != op_a_q[31]);
  end

  // Next-state, operand/result capture and request accept.
  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    owner_d   = owner_q;
    last_d    = last_q;
    op_a_d    = op_a_q;
    op_b_d    = op_b_q;
    op_cin_d  = op_cin_q;
    sum_d     = sum_q;
    cout_d    = cout_q;
    of_d      = of_q;
    req_ready = 2'b00;
    unique case (state_q)
      StIdle: begin
        // Ready follows valid here, so any valid request is a handshake.
        if ((|req_valid) && !rst) begin
          req_ready[grant_id] = 1'b1;
          owner_d  = grant_id;
          op_a_d   = grant_id ? req_a1 : req_a0;
          op_b_d   = grant_id ? req_b1 : req_b0;
          op_cin_d = grant_id ? req_cin1 : req_cin0;
          cnt_d    = CntLoad;
          state_d  = StCalc;
        end
      end
      StCalc: begin
        if (cnt_q == 4'd0) begin
          sum_d   = cla_sum;
          cout_d  = cla_c[32];
          of_d    = cla_of;
          state_d = StResp;
        end else begin
          cnt_d = cnt_q - 4'd1;
        end
      end
      StResp: begin
        if (rsp_ready[owner_q]) begin
          last_d  = owner_q;
          state_d = StIdle;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  // State and datapath registers; reset aborts any operation in flight.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= StIdle;
      cnt_q    <= 4'd0;
      owner_q  <= 1'b0;
      last_q   <= 1'b1;
      op_a_q   <= '0;
      op_b_q   <= '0;
      op_cin_q <= 1'b0;
      sum_q    <= '0;
      cout_q   <= 1'b0;
      of_q     <= 1'b0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      owner_q  <= owner_d;
      last_q   <= last_d;
      op_a_q   <= op_a_d;
      op_b_q   <= op_b_d;
      op_cin_q <= op_cin_d;
      sum_q    <= sum_d;
      cout_q   <= cout_d;
      of_q     <= of_d;
    end
  end

  // Response outputs come straight from registers.
  always_comb begin
    rsp_valid = 2'b00;
    if (state_q == StResp) rsp_valid = owner_q ? 2'b10 : 2'b01;
    rsp_sum  = sum_q;
    rsp_cout = cout_q;
    rsp_of   = of_q;
    busy     = (state_q != StIdle);
  end

endmodule

// File: tb/tb_cla_share_arbiter.sv
// Scoreboard bench: two instances (CALC_CYCLES 1 and 4) share stimulus; sel picks the
// observed one. Expected results are pushed at each accept and popped at each response.
module tb_cla_share_arbiter;

  typedef struct {
    logic        owner;
    logic [31:0] sum;
    logic        cout;
    logic        of;
  } exp_t;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [1:0]  req_valid = 2'b00;
  logic [31:0] req_a0 = '0, req_b0 = '0, req_a1 = '0, req_b1 = '0;
  logic        req_cin0 = 1'b0, req_cin1 = 1'b0;
  logic [1:0]  rsp_ready = 2'b11;

  logic [1:0]  rdy1, rv1, rdy4, rv4;
  logic [31:0] sum1, sum4;
  logic        cout1, of1, busy1, cout4, of4, busy4;

  logic        sel = 1'b0;
  logic [1:0]  m_ready, m_rv;
  logic [31:0] m_sum;
  logic        m_cout, m_of, m_busy;

  int   n_checks = 0;
  int   n_fail = 0;
  int   cyc = 0;
  int   acc_cyc = 0;
  int   exp_lat = 2;
  int   rsp_cnt = 0;
  int   rv_cnt = 0;
  int   rv_before;
  logic [1:0] prev_rv = 2'b00;
  logic mon_g;
  exp_t exp_q[$];
  exp_t mon_e;
  logic grants[$];

  cla_share_arbiter #(.CALC_CYCLES(1)) dut1 (
    .clk(clk), .rst(rst), .req_valid(req_valid), .req_ready(rdy1),
    .req_a0(req_a0), .req_b0(req_b0), .req_cin0(req_cin0),
    .req_a1(req_a1), .req_b1(req_b1), .req_cin1(req_cin1),
    .rsp_valid(rv1), .rsp_ready(rsp_ready), .rsp_sum(sum1), .rsp_cout(cout1),
    .rsp_of(of1), .busy(busy1)
  );

  cla_share_arbiter #(.CALC_CYCLES(4)) dut4 (
    .clk(clk), .rst(rst), .req_valid(req_valid), .req_ready(rdy4),
    .req_a0(req_a0), .req_b0(req_b0), .req_cin0(req_cin0),
    .req_a1(req_a1), .req_b1(req_b1), .req_cin1(req_cin1),
    .rsp_valid(rv4), .rsp_ready(rsp_ready), .rsp_sum(sum4), .rsp_cout(cout4),
    .rsp_of(of4), .busy(busy4)
  );

  always_comb begin
    m_ready = sel ? rdy4 : rdy1;
    m_rv    = sel ? rv4 : rv1;
    m_sum   = sel ? sum4 : sum1;
    m_cout  = sel ? cout4 : cout1;
    m_of    = sel ? of4 : of1;
    m_busy  = sel ? busy4 : busy1;
  end

  always #5 clk = ~clk;

  initial forever begin
    @(posedge clk);
    cyc++;
  end

  function automatic exp_t model(logic own, logic [31:0] a, logic [31:0] b, logic cin);
    exp_t e;
    logic [32:0] r;
    r = {1'b0, a} + {1'b0, b} + {32'd0, cin};
    e.owner = own;
    e.sum   = r[31:0];
    e.cout  = r[32];
    e.of    = (a[31] == b[31]) && (r[31] != a[31]);
    return e;
  endfunction

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  // Monitor: push on accept, pop and compare on response handshake.
  initial forever begin
    @(negedge clk);
    if (!rst) begin
      if ((m_ready & req_valid) != 2'b00) begin
        check_eq("ready_onehot", 64'(m_ready == 2'b01 || m_ready == 2'b10), 64'd1);
        mon_g = m_ready[1];
        grants.push_back(mon_g);
        if (mon_g) exp_q.push_back(model(1'b1, req_a1, req_b1, req_cin1));
        else       exp_q.push_back(model(1'b0, req_a0, req_b0, req_cin0));
        acc_cyc = cyc;
      end
      if (m_rv != 2'b00) begin
        rv_cnt++;
        if (prev_rv == 2'b00) check_eq("latency", 64'(cyc - acc_cyc), 64'(exp_lat));
      end
      if ((m_rv & rsp_ready) != 2'b00) begin
        if (exp_q.size() == 0) begin
          check_eq("rsp_unexpected", 64'(m_rv), 64'd0);
        end else begin
          mon_e = exp_q.pop_front();
          check_eq("rsp_valid", 64'(m_rv), mon_e.owner ? 64'd2 : 64'd1);
          check_eq("rsp_sum", 64'(m_sum), 64'(mon_e.sum));
          check_eq("rsp_cout", 64'(m_cout), 64'(mon_e.cout));
          check_eq("rsp_of", 64'(m_of), 64'(mon_e.of));
          rsp_cnt++;
        end
      end
    end
    prev_rv = rst ? 2'b00 : m_rv;
  end

  task automatic tick(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic wait_grants(input int target);
    int t = 0;
    while (grants.size() < target && t < 100) begin
      tick(1);
      t++;
    end
    check_eq("grant_timeout", 64'(grants.size() >= target), 64'd1);
  endtask

  task automatic wait_resp(input int target);
    int t = 0;
    while (rsp_cnt < target && t < 100) begin
      tick(1);
      t++;
    end
    check_eq("resp_timeout", 64'(rsp_cnt >= target), 64'd1);
  endtask

  task automatic set_ops(input logic who, input logic [31:0] a, input logic [31:0] b,
                         input logic cin);
    if (who) begin
      req_a1 = a; req_b1 = b; req_cin1 = cin;
    end else begin
      req_a0 = a; req_b0 = b; req_cin0 = cin;
    end
  endtask

  // One operation; operands are scrambled right after the accept edge.
  task automatic single_op(input logic who, input logic [31:0] a, input logic [31:0] b,
                           input logic cin);
    int g;
    int r;
    g = grants.size() + 1;
    r = rsp_cnt + 1;
    set_ops(who, a, b, cin);
    req_valid = who ? 2'b10 : 2'b01;
    wait_grants(g);
    req_valid = 2'b00;
    set_ops(who, $urandom, $urandom, 1'($urandom));
    wait_resp(r);
  endtask

  task automatic do_reset();
    rst = 1'b1;
    tick(2);
    exp_q.delete();
    grants.delete();
    rst = 1'b0;
    tick(1);
  endtask

  initial begin
    // Reset values, with requests pending to show ready stays low.
    req_valid = 2'b11;
    #2;
    check_eq("reset_busy", 64'(m_busy), 64'd0);
    check_eq("reset_rsp_valid", 64'(m_rv), 64'd0);
    check_eq("reset_sum", 64'(m_sum), 64'd0);
    check_eq("reset_cout", 64'(m_cout), 64'd0);
    check_eq("reset_of", 64'(m_of), 64'd0);
    check_eq("reset_req_ready", 64'(m_ready), 64'd0);
    req_valid = 2'b00;
    tick(1);
    rst = 1'b0;
    tick(1);

    // CALC_CYCLES = 1
    sel = 1'b0;
    exp_lat = 2;
    single_op(1'b0, 32'h7FFF_FFFF, 32'h0000_0001, 1'b0);
    single_op(1'b1, 32'hFFFF_FFFF, 32'h0000_0001, 1'b1);
    for (int i = 0; i < 4; i++) begin
      single_op(1'($urandom_range(0, 1)), $urandom, $urandom, 1'($urandom));
    end

    // Tie after reset: expect 0,1,0,1.
    do_reset();
    set_ops(1'b0, 32'h0000_0010, 32'h0000_0020, 1'b0);
    set_ops(1'b1, 32'h8000_0000, 32'h8000_0000, 1'b1);
    rsp_cnt = 0;
    req_valid = 2'b11;
    wait_grants(4);
    req_valid = 2'b00;
    wait_resp(4);
    for (int i = 0; i < 4; i++) begin
      check_eq("tie_order", 64'(grants[i]), 64'(i % 2));
    end

    // Backpressure on requester 1 with requester 0 pending.
    rsp_ready = 2'b00;
    set_ops(1'b1, 32'h1234_5678, 32'h1111_1111, 1'b1);
    req_valid = 2'b10;
    wait_grants(grants.size() + 1);
    set_ops(1'b0, 32'h0000_0005, 32'h0000_0006, 1'b0);
    req_valid = 2'b01;
    for (int t = 0; t < 20 && m_rv == 2'b00; t++) tick(1);
    for (int i = 0; i < 5; i++) begin
      check_eq("bp_rsp_valid", 64'(m_rv), 64'd2);
      check_eq("bp_sum", 64'(m_sum), 64'(exp_q[0].sum));
      check_eq("bp_req_ready", 64'(m_ready), 64'd0);
      check_eq("bp_busy", 64'(m_busy), 64'd1);
      rsp_ready = (i == 2 || i == 3) ? 2'b01 : 2'b00;
      tick(1);
    end
    rv_before = rsp_cnt;
    rsp_ready = 2'b11;
    tick(1);
    check_eq("bp_idle_busy", 64'(m_busy), 64'd0);
    check_eq("bp_idle_ready", 64'(m_ready), 64'd1);
    wait_grants(grants.size() + 1);
    req_valid = 2'b00;
    wait_resp(rv_before + 2);

    // CALC_CYCLES = 4
    sel = 1'b1;
    exp_lat = 5;
    do_reset();
    rsp_cnt = 0;
    single_op(1'b0, 32'hDEAD_BEEF, 32'h2152_4111, 1'b1);
    single_op(1'b1, $urandom, $urandom, 1'($urandom));
    single_op(1'b0, 32'h8000_0000, 32'hFFFF_FFFF, 1'b0);

    // Reset one cycle after accept; last served was requester 0.
    set_ops(1'b1, 32'h0000_0001, 32'h0000_0002, 1'b0);
    req_valid = 2'b10;
    wait_grants(grants.size() + 1);
    req_valid = 2'b00;
    rst = 1'b1;
    #1;
    check_eq("abort_busy", 64'(m_busy), 64'd0);
    check_eq("abort_rsp_valid", 64'(m_rv), 64'd0);
    rv_before = rv_cnt;
    exp_q.delete();
    grants.delete();
    tick(2);
    rst = 1'b0;
    tick(10);
    check_eq("abort_no_rsp", 64'(rv_cnt), 64'(rv_before));
    rsp_cnt = 0;
    set_ops(1'b0, 32'h0000_0100, 32'h0000_0200, 1'b1);
    set_ops(1'b1, 32'h0000_0300, 32'h0000_0400, 1'b0);
    req_valid = 2'b11;
    wait_grants(1);
    req_valid = 2'b00;
    check_eq("abort_tie_grant", 64'(grants[0]), 64'd0);
    wait_resp(1);

    tick(3);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule
